// File: rtl/mul8_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul8_seq_ctrl_if
//  Description : Operand, result and shared-multiplier signals of the 8x8
//                sequential multiply controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface mul8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        busy;

    // Requester side together with the shared 4x4 multiplier.
    modport master (
        output in_valid, a, b, out_ready, mul_p,
        input  in_ready, out_valid, p, mul_a, mul_b, busy
    );

    // Controller side.
    modport slave (
        input  in_valid, a, b, out_ready, mul_p,
        output in_ready, out_valid, p, mul_a, mul_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul8_seq_ctrl
//  Description : Unsigned 8x8 -> 16 multiply built from four passes through a
//                shared 4x4 multiplier, accumulating shifted partial products.
//  Revision    : 1.0  initial release
// ============================================================================
module mul8_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mul8_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last value of the step counter before DONE; a registered multiplier
    // needs one extra cycle to drain the final partial product.
    localparam logic [2:0] c_LAST = 3'(3 + MUL_LAT);
    localparam logic [2:0] c_LAT  = 3'(MUL_LAT);

    state_t      r_state;
    logic [2:0]  r_k;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_p;
    logic [3:0]  r_mul_a;
    logic [3:0]  r_mul_b;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;

    logic        w_acc_en;
    logic [2:0]  w_j;
    logic [15:0] w_sum;
    logic [7:0]  w_next_pair;

    // Nibble pair for step j as {mul_a, mul_b}; steps past 3 issue zeros.
    function automatic logic [7:0] pair_sel(input logic [2:0] j,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        logic [7:0] v;
        case (j)
            3'd0:    v = {x[3:0], y[3:0]};
            3'd1:    v = {x[7:4], y[3:0]};
            3'd2:    v = {x[3:0], y[7:4]};
            3'd3:    v = {x[7:4], y[7:4]};
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Zero-extended partial product placed at the weight of step j.
    function automatic logic [15:0] weighted(input logic [2:0] j,
                                             input logic [7:0] pp);
        logic [15:0] v;
        case (j)
            3'd0:       v = {8'd0, pp};
            3'd1, 3'd2: v = {4'd0, pp, 4'd0};
            3'd3:       v = {pp, 8'd0};
            default:    v = 16'd0;
        endcase
        return v;
    endfunction

    // Accumulator update: the product arriving now belongs to the pair issued
    // MUL_LAT cycles earlier, so nothing is added until that pair returns.
    always_comb begin
        w_acc_en    = (MUL_LAT == 0) || (r_k != 3'd0);
        w_j         = r_k - c_LAT;
        w_sum       = r_acc + (w_acc_en ? weighted(w_j, bus.mul_p) : 16'd0);
        w_next_pair = pair_sel(r_k + 3'd1, r_a, r_b);
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= 3'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_acc       <= 16'd0;
            r_p         <= 16'd0;
            r_mul_a     <= 4'd0;
            r_mul_b     <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_acc      <= 16'd0;
                        r_k        <= 3'd0;
                        r_mul_a    <= bus.a[3:0];
                        r_mul_b    <= bus.b[3:0];
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_acc              <= w_sum;
                    r_k                <= r_k + 3'd1;
                    {r_mul_a, r_mul_b} <= w_next_pair;
                    if (r_k == c_LAST) begin
                        r_p         <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.p         = r_p;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul8_seq_ctrl
//  Description : Scoreboard bench for mul8_seq_ctrl, one instance with a
//                combinational 4x4 multiplier and one with a registered one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul8_seq_ctrl;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         acc_edge;
    } job_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0;
    logic       rst_n1;
    logic       iv   [2];
    logic [7:0] av   [2];
    logic [7:0] bv   [2];
    logic       ordy [2];

    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   timeouts = 0;
    bit   fin      = 1'b0;
    bit   fin_done = 1'b0;
    job_t q [2][$];

    int          m_step [2];
    logic        m_ovp  [2];
    logic        m_rstp [2];
    logic [15:0] m_held [2];

    mul8_seq_ctrl_if bus0 ();
    mul8_seq_ctrl_if bus1 ();

    assign bus0.in_valid  = iv[0];
    assign bus0.a         = av[0];
    assign bus0.b         = bv[0];
    assign bus0.out_ready = ordy[0];
    assign bus1.in_valid  = iv[1];
    assign bus1.a         = av[1];
    assign bus1.b         = bv[1];
    assign bus1.out_ready = ordy[1];

    // Shared multiplier models: combinational and one-cycle registered.
    assign bus0.mul_p = {4'd0, bus0.mul_a} * {4'd0, bus0.mul_b};
    always @(posedge clk) bus1.mul_p <= {4'd0, bus1.mul_a} * {4'd0, bus1.mul_b};

    mul8_seq_ctrl #(.MUL_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(bus0));
    mul8_seq_ctrl #(.MUL_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(bus1));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    function automatic logic ovld(input int d);
        return (d == 0) ? bus0.out_valid : bus1.out_valid;
    endfunction

    // Reference nibble schedule: low/low, high/low, low/high, high/high.
    function automatic logic [7:0] exp_pair(input logic [7:0] x, input logic [7:0] y, input int j);
        case (j)
            0:       return {x[3:0], y[3:0]};
            1:       return {x[7:4], y[3:0]};
            2:       return {x[3:0], y[7:4]};
            3:       return {x[7:4], y[7:4]};
            default: return 8'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor for one instance; inputs seen here apply at the next edge.
    task automatic mon(input int d, input int lat, input logic rst_now, input logic ir,
                       input logic ov, input logic ordy_now, input logic [15:0] pv,
                       input logic [3:0] ma, input logic [3:0] mb, input logic bz);
        if (!m_rstp[d]) begin
            chk("reset_state", d, {5'd0, ir, ov, bz, ma, mb, pv}, {5'd0, 1'b1, 26'd0});
            m_step[d] = 0;
            m_ovp[d]  = 1'b0;
        end else begin
            if (bz && !ov) begin
                if (q[d].size() == 0)
                    chk("step_without_job", d, 1, 0);
                else
                    chk("mul_operands", d, {ma, mb}, exp_pair(q[d][0].a, q[d][0].b, m_step[d]));
                m_step[d]++;
            end else begin
                chk("mul_idle_zero", d, {ma, mb}, 0);
            end
            chk("in_ready", d, ir, !bz);
            if (m_ovp[d] && !ov)
                chk("out_valid_held", d, ov, 1);
            if (ov) begin
                if (q[d].size() == 0) begin
                    chk("result_without_job", d, 1, 0);
                end else begin
                    if (!m_ovp[d]) begin
                        chk("latency", d, cyc - q[d][0].acc_edge, 4 + lat);
                        chk("step_cycles", d, m_step[d], 4 + lat);
                        m_held[d] = pv;
                    end else begin
                        chk("p_stable", d, pv, m_held[d]);
                    end
                    if (ordy_now) begin
                        chk("product", d, pv, int'(q[d][0].a) * int'(q[d][0].b));
                        void'(q[d].pop_front());
                        m_step[d] = 0;
                    end
                end
            end
            m_ovp[d] = ov && !ordy_now;
        end
        m_rstp[d] = rst_now;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        mon(0, 0, rst_n0, bus0.in_ready, bus0.out_valid, ordy[0], bus0.p, bus0.mul_a, bus0.mul_b, bus0.busy);
        mon(1, 1, rst_n1, bus1.in_ready, bus1.out_valid, ordy[1], bus1.p, bus1.mul_a, bus1.mul_b, bus1.busy);
        if (fin && !fin_done) begin
            chk("timeouts", 0, timeouts, 0);
            chk("queue_empty", 0, q[0].size(), 0);
            chk("queue_empty", 1, q[1].size(), 0);
            fin_done = 1'b1;
        end
    end

    // Offer one operand pair and record the expected job once accepted.
    task automatic send(input int d, input logic [7:0] x, input logic [7:0] y, input bit rnd_bp);
        int n = 0;
        @(posedge clk); #1;
        iv[d] = 1'b1;
        av[d] = x;
        bv[d] = y;
        while (!rdy(d) && n < 200) begin
            if (rnd_bp) ordy[d] = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (rdy(d)) q[d].push_back('{x, y, cyc + 1});
        else timeouts++;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        av[d] = 8'($urandom);
        bv[d] = 8'($urandom);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (q[d].size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q[d].size() != 0) timeouts++;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; av[i] = 8'd0; bv[i] = 8'd0; ordy[i] = 1'b1;
            m_step[i] = 0; m_ovp[i] = 1'b0; m_rstp[i] = 1'b1; m_held[i] = 16'd0;
        end
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n0 = 1'b1;

        // Directed products, back-to-back with out_ready high.
        send(0, 8'h12, 8'h34, 1'b0);
        send(0, 8'hFF, 8'hFF, 1'b0);
        send(0, 8'h00, 8'hA7, 1'b0);
        drain(0);

        // Result backpressure with a competing request pending.
        ordy[0] = 1'b0;
        send(0, 8'h5A, 8'hC3, 1'b0);
        n = 0;
        while (!ovld(0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ovld(0)) timeouts++;
        iv[0] = 1'b1; av[0] = 8'h11; bv[0] = 8'h22;
        repeat (3) begin
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        send(0, 8'h11, 8'h22, 1'b0);
        drain(0);

        // Abort a job with reset in its second step cycle.
        send(0, 8'h33, 8'h44, 1'b0);
        @(posedge clk); #1;
        rst_n0 = 1'b0;
        @(posedge clk); #1;
        q[0].delete();
        rst_n0 = 1'b1;
        send(0, 8'h0F, 8'h10, 1'b0);
        drain(0);

        // Random operands with random backpressure.
        for (int i = 0; i < 40; i++) send(0, 8'($urandom), 8'($urandom), 1'b1);
        ordy[0] = 1'b1;
        drain(0);

        // Registered multiplier instance.
        @(posedge clk); #1;
        rst_n1 = 1'b1;
        send(1, 8'h9C, 8'h47, 1'b0);
        send(1, 8'hFF, 8'hFF, 1'b0);
        drain(1);
        for (int i = 0; i < 20; i++) send(1, 8'($urandom), 8'($urandom), 1'b1);
        ordy[1] = 1'b1;
        drain(1);

        fin = 1'b1;
        n = 0;
        while (!fin_done && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (!fin_done) $display("FAIL finalize: monitor did not complete final checks");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
